cu_mod1_sched: RTL and testbench

Control unit for the second FFT processing module (radix-2² SDF stage pair plus twiddle multiply), driven by the frame-start alert of the preceding module. It runs a frame-phase counter and a three-state FSM (IDLE/RUN/DRAIN) that generate the BF2I and BF2II enables, the twiddle ROM address/enable and the output valid. It also emits the frame-start alert for the next module. Back-to-back frames, pipeline drain and protocol violations are handled here, so the datapath holds no control logic.

---
 rtl/cu_mod1_sched.sv | 140 ++++++++++++++
 tb/tb_cu_mod1_sched.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/cu_mod1_sched.sv
// Control unit for the second FFT module: frame-phase counter plus IDLE/RUN/DRAIN FSM.
// Optional build macro CU_MOD1_ERR_CNT_EN adds a saturating err_cnt[7:0] output.
module cu_mod1_sched #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             alert_in,
  output logic             bf1_en,
  output logic             bf2_en,
  output logic             tw_en,
  output logic [CNT_W-1:0] tw_addr,
  output logic             valid_out,
  output logic             alert_out,
  output logic             busy,
  output logic             err_overrun
`ifdef CU_MOD1_ERR_CNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  // state   | meaning
  // IDLE    | waiting for a frame-start alert, all outputs low
  // RUN     | accepting frame samples, pipeline filling or full
  // DRAIN   | no new frame, flushing LAT samples out of the delay lines
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam int               F      = 1 << CNT_W;
  localparam int               LAT    = (3 * F) / 4;
  localparam logic [CNT_W-1:0] LAT_C  = CNT_W'(LAT);
  localparam logic [CNT_W-1:0] C_LAST = '1;
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_fill;
  logic [CNT_W-1:0] r_drain;
  logic             r_err_ovr;

  logic [1:0]       w_state_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic [CNT_W-1:0] w_fill_nx;
  logic [CNT_W-1:0] w_drain_nx;
  logic             w_reject;
  logic             w_busy;
  logic             w_valid;

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_fill_nx  = r_fill;
    w_drain_nx = r_drain;
    w_reject   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (alert_in) begin
          w_state_nx = S_RUN;
          w_cnt_nx   = '0;
          w_fill_nx  = '0;
        end
      end
      S_RUN: begin
        w_cnt_nx = r_cnt + C_ONE;
        if (r_fill != LAT_C) w_fill_nx = r_fill + C_ONE;
        if (r_cnt == C_LAST) begin
          // an alert exactly on the last sample chains the next frame without a drain
          if (!alert_in) begin
            w_state_nx = S_DRAIN;
            w_drain_nx = LAT_C;
          end
        end else begin
          w_reject = alert_in;
        end
      end
      S_DRAIN: begin
        w_cnt_nx   = r_cnt + C_ONE;
        w_drain_nx = r_drain - C_ONE;
        w_reject   = alert_in;
        if (r_drain == C_ONE) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
          w_drain_nx = '0;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
        w_fill_nx  = '0;
        w_drain_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_fill    <= '0;
      r_drain   <= '0;
      r_err_ovr <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_fill    <= w_fill_nx;
      r_drain   <= w_drain_nx;
      r_err_ovr <= w_reject;
    end
  end

  // decodes come only from registers so the async reset clears them in the same cycle
  assign w_busy  = (r_state != S_IDLE);
  assign w_valid = ((r_state == S_RUN) && (r_fill == LAT_C)) || (r_state == S_DRAIN);

  assign busy        = w_busy;
  assign bf1_en      = w_busy & r_cnt[CNT_W-1];
  assign bf2_en      = w_busy & r_cnt[CNT_W-2];
  assign valid_out   = w_valid;
  assign tw_en       = w_valid;
  assign tw_addr     = w_valid ? (r_cnt - LAT_C) : '0;
  assign alert_out   = w_valid && (r_cnt == LAT_C);
  assign err_overrun = r_err_ovr;

`ifdef CU_MOD1_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_err_cnt <= 8'd0;
    end else if (r_err_ovr && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_cu_mod1_sched.sv
// Directed bench for cu_mod1_sched (F = 32, LAT = 24) with alert_out/err_overrun scoreboards.
// Checks err_cnt as well when built with CU_MOD1_ERR_CNT_EN.
module tb_cu_mod1_sched;
  localparam int LAT = 24;

  logic       clk;
  logic       rstn;
  logic       alert_in;
  logic       bf1_en;
  logic       bf2_en;
  logic       tw_en;
  logic [4:0] tw_addr;
  logic       valid_out;
  logic       alert_out;
  logic       busy;
  logic       err_overrun;
`ifdef CU_MOD1_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  cu_mod1_sched #(.CNT_W(5)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .alert_in    (alert_in),
    .bf1_en      (bf1_en),
    .bf2_en      (bf2_en),
    .tw_en       (tw_en),
    .tw_addr     (tw_addr),
    .valid_out   (valid_out),
    .alert_out   (alert_out),
    .busy        (busy),
    .err_overrun (err_overrun)
`ifdef CU_MOD1_ERR_CNT_EN
    ,
    .err_cnt     (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int f_t0   = -1000;
  int f_n    = 0;
  int q_alert[$];
  int q_err[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // expected outputs from frame timing: busy T+1..T+32n+24, cnt=(c-T-1)%32, valid from T+25
  task automatic check_now();
    int   k;
    bit   b;
    bit   v;
    bit   ea;
    bit   ee;
    logic [4:0] cnt;
    logic [4:0] tw;
    k   = cyc - f_t0 - 1;
    b   = (f_n > 0) && (k >= 0) && (k < 32 * f_n + LAT);
    v   = b && (k >= LAT);
    cnt = b ? 5'(k % 32) : 5'd0;
    tw  = v ? 5'((k - LAT) % 32) : 5'd0;
    ea  = (q_alert.size() > 0) && (q_alert[0] == cyc);
    if (ea) void'(q_alert.pop_front());
    ee  = (q_err.size() > 0) && (q_err[0] == cyc);
    if (ee) void'(q_err.pop_front());
    chk("busy",        32'(busy),        32'(b));
    chk("bf1_en",      32'(bf1_en),      32'(b & cnt[4]));
    chk("bf2_en",      32'(bf2_en),      32'(b & cnt[3]));
    chk("valid_out",   32'(valid_out),   32'(v));
    chk("tw_en",       32'(tw_en),       32'(v));
    chk("tw_addr",     32'(tw_addr),     32'(tw));
    chk("alert_out",   32'(alert_out),   32'(ea));
    chk("err_overrun", 32'(err_overrun), 32'(ee));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    check_now();
  endtask

  task automatic pulse();
    alert_in = 1'b1;
    tick();
    alert_in = 1'b0;
  endtask

  int t0;

  initial begin
    rstn     = 1'b0;
    alert_in = 1'b0;

    // reset held: alert_in toggling must have no effect
    for (int i = 0; i < 6; i++) begin
      alert_in = i[0];
      tick();
    end
    alert_in = 1'b0;
    tick();
    rstn = 1'b1;
    repeat (2) tick();
`ifdef CU_MOD1_ERR_CNT_EN
    chk("err_cnt_reset", 32'(err_cnt), 32'd0);
`endif

    // single frame
    t0 = cyc; f_t0 = t0; f_n = 1; q_alert.push_back(t0 + 25);
    pulse();
    repeat (59) tick();

    // back-to-back frames at T and T+32
    t0 = cyc; f_t0 = t0; f_n = 1; q_alert.push_back(t0 + 25);
    pulse();
    repeat (31) tick();
    f_n = 2; q_alert.push_back(t0 + 57);
    pulse();
    repeat (59) tick();

    // misaligned alert at T+10 is rejected
    t0 = cyc; f_t0 = t0; f_n = 1; q_alert.push_back(t0 + 25);
    pulse();
    repeat (9) tick();
    q_err.push_back(t0 + 11);
    pulse();
    repeat (50) tick();
`ifdef CU_MOD1_ERR_CNT_EN
    chk("err_cnt_one", 32'(err_cnt), 32'd1);
`endif

    // alert in DRAIN rejected, alert in the IDLE cycle accepted
    t0 = cyc; f_t0 = t0; f_n = 1; q_alert.push_back(t0 + 25);
    pulse();
    repeat (39) tick();
    q_err.push_back(t0 + 41);
    pulse();
    repeat (16) tick();
    chk("idle_at_57", 32'(busy), 32'd0);
    f_t0 = t0 + 57; q_alert.push_back(t0 + 82);
    pulse();
    repeat (60) tick();
`ifdef CU_MOD1_ERR_CNT_EN
    chk("err_cnt_two", 32'(err_cnt), 32'd2);
`endif

    // mid-frame reset, then a fresh frame
    t0 = cyc; f_t0 = t0; f_n = 1; q_alert.push_back(t0 + 25);
    pulse();
    repeat (19) tick();
    rstn = 1'b0;
    #1;
    f_n = 0;
    q_alert.delete();
    check_now();
    repeat (2) tick();
    rstn = 1'b1;
    repeat (8) tick();
`ifdef CU_MOD1_ERR_CNT_EN
    chk("err_cnt_cleared", 32'(err_cnt), 32'd0);
`endif
    f_t0 = t0 + 30; f_n = 1; q_alert.push_back(t0 + 55);
    pulse();
    repeat (60) tick();

    chk("alert_queue_drained", 32'(q_alert.size()), 32'd0);
    chk("err_queue_drained",   32'(q_err.size()),   32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
